// File: rtl/pool_window_sequencer.sv
// 2x2 stride-2 max-pool sequencer: walks every window of a CHANNELS x IN_DIM x IN_DIM map,
// issues four single-cycle reads per window and writes the unsigned maximum to the flatten buffer.
module pool_window_sequencer #(
  parameter int BITWIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int IN_DIM   = 16,
  localparam int RD_AW   = $clog2(CHANNELS * IN_DIM * IN_DIM),
  localparam int WR_AW   = $clog2(CHANNELS * IN_DIM * IN_DIM / 4)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                rd_en,
  output logic [RD_AW-1:0]    rd_addr,
  input  logic [BITWIDTH-1:0] rd_data,
  output logic                wr_en,
  output logic [WR_AW-1:0]    wr_addr,
  output logic [BITWIDTH-1:0] wr_data,
  output logic                busy,
  output logic                done
);

  // state | meaning
  // IDLE  | waiting for start (ignored while the done pulse is up)
  // RD0-3 | read window pixels (r,c) (r,c+1) (r+1,c) (r+1,c+1)
  // CMP   | fold last sample into max, register the write
  // FIN   | last write on the bus, done follows
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_CMP  = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  localparam int HALF_AW = $clog2(IN_DIM / 2);
  localparam logic [RD_AW-1:0] PC_MASK  = RD_AW'(IN_DIM / 2 - 1);
  localparam logic [RD_AW-1:0] ROW_STEP = RD_AW'(IN_DIM);
  localparam logic [WR_AW-1:0] LAST_WIN = {WR_AW{1'b1}};

  state_t              state_q, state_d;
  logic [WR_AW-1:0]    win_q, win_d;
  logic [BITWIDTH-1:0] acc_q, acc_d;
  logic                wr_en_q, wr_en_d;
  logic [WR_AW-1:0]    wr_addr_q, wr_addr_d;
  logic [BITWIDTH-1:0] wr_data_q, wr_data_d;
  logic                done_q, done_d;

  logic [RD_AW-1:0]    win_ext;
  logic [RD_AW-1:0]    base;
  logic [BITWIDTH-1:0] cmp_max;
  logic                last_win;

  // Window index is {c, pr, pc}; the base doubles pr and pc into row/column.
  assign win_ext  = RD_AW'(win_q);
  assign base     = ((win_ext >> HALF_AW) << (HALF_AW + 2)) | ((win_ext & PC_MASK) << 1);
  assign cmp_max  = (rd_data > acc_q) ? rd_data : acc_q;
  assign last_win = (win_q == LAST_WIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = (state_q == S_FIN);
    unique case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          state_d = S_RD0;
          win_d   = '0;
        end
      end
      S_RD0: state_d = S_RD1;
      // Read data lags rd_en by one cycle, so RD1 sees the RD0 sample.
      S_RD1: begin
        state_d = S_RD2;
        acc_d   = rd_data;
      end
      S_RD2: begin
        state_d = S_RD3;
        acc_d   = cmp_max;
      end
      S_RD3: begin
        state_d = S_CMP;
        acc_d   = cmp_max;
      end
      S_CMP: begin
        state_d   = last_win ? S_FIN : S_RD0;
        wr_en_d   = 1'b1;
        wr_addr_d = win_q;
        wr_data_d = cmp_max;
        win_d     = win_q + WR_AW'(1);
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_RD0: begin
        rd_en   = 1'b1;
        rd_addr = base;
      end
      S_RD1: begin
        rd_en   = 1'b1;
        rd_addr = base + RD_AW'(1);
      end
      S_RD2: begin
        rd_en   = 1'b1;
        rd_addr = base + ROW_STEP;
      end
      S_RD3: begin
        rd_en   = 1'b1;
        rd_addr = base + ROW_STEP + RD_AW'(1);
      end
      default: begin
        rd_en   = 1'b0;
        rd_addr = '0;
      end
    endcase
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Scoreboard bench for pool_window_sequencer: a memory model answers reads, the driver queues
// expected reads/writes per run, and a negedge monitor pops and compares whatever the DUT emits.
module tb_pool_window_sequencer;

  localparam int CHANNELS = 4;
  localparam int IN_DIM   = 16;
  localparam int HALF     = IN_DIM / 2;
  localparam int MSIZE    = CHANNELS * IN_DIM * IN_DIM;
  localparam int NWIN     = MSIZE / 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rd_data = 8'd0;
  logic       rd_en, wr_en, busy, done;
  logic [9:0] rd_addr;
  logic [7:0] wr_addr, wr_data;

  pool_window_sequencer #(.BITWIDTH(8), .CHANNELS(CHANNELS), .IN_DIM(IN_DIM)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [MSIZE];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wr_q [$];
  logic [9:0] rd_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [7:0] wr_log [NWIN];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected traffic for one full map, derived from the bench's own copy of memory.
  function automatic void push_run();
    int k;
    int base;
    int a;
    logic [7:0] m;
    wr_t w;
    k = 0;
    for (int c = 0; c < CHANNELS; c++)
      for (int pr = 0; pr < HALF; pr++)
        for (int pc = 0; pc < HALF; pc++) begin
          base = c * IN_DIM * IN_DIM + pr * 2 * IN_DIM + pc * 2;
          m = mem[base];
          for (int j = 0; j < 4; j++) begin
            a = base + (j / 2) * IN_DIM + (j % 2);
            rd_q.push_back(10'(a));
            if (mem[a] > m) m = mem[a];
          end
          w.addr = 8'(k);
          w.data = m;
          wr_q.push_back(w);
          k++;
        end
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("busy_low_with_done", busy, 0);
    end
    if (wr_en) begin
      wr_t e;
      check("rd_per_wr", rd_cnt, 4);
      rd_cnt = 0;
      if (wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: got addr %0d data %0d expected no write (cycle %0d)",
                 wr_addr, wr_data, cyc);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
      wr_log[wr_addr] = wr_data;
      wr_cnt++;
    end
    if (rd_en) begin
      rd_cnt++;
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got addr %0d expected no read (cycle %0d)", rd_addr, cyc);
      end else begin
        check("rd_addr", rd_addr, rd_q.pop_front());
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int t0, input string name);
    int guard;
    guard = 0;
    while (!done && guard < 1500) begin
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no done within %0d cycles expected done at +1282", name, guard);
    end else begin
      check(name, cyc - t0, 1282);
    end
  endtask

  task automatic run_full(input string name);
    int t0;
    push_run();
    wr_cnt   = 0;
    done_cnt = 0;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, name);
    check("writes_per_run", wr_cnt, NWIN);
    check("wr_queue_drained", wr_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);
    @(negedge clk);
    check("single_done", done_cnt, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int t0;
    int t1;
    int offs [4];
    offs = '{0, 1, 16, 17};

    for (int i = 0; i < MSIZE; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Start in the first cycle out of reset, with stray starts that must be ignored.
    push_run();
    wr_cnt   = 0;
    done_cnt = 0;
    reset    = 1'b0;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 1);
    check("busy_cycle1", busy, 1);
    wait_until(t0 + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 600);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 1281);
    check("busy_last_write", busy, 1);
    check("last_write_cycle", wr_en, 1);
    wait_until(t0 + 1282);
    check("done_cycle", done, 1);
    check("busy_done_cycle", busy, 0);
    check("writes_run1", wr_cnt, NWIN);
    start = 1'b1;
    @(negedge clk);
    check("single_done_run1", done_cnt, 1);
    check("done_one_cycle", done, 0);
    check("idle_after_done_rd_en", rd_en, 0);
    check("k0_value", wr_log[0], 17);
    check("k7_value", wr_log[7], 31);
    check("k8_value", wr_log[8], 49);
    check("k255_value", wr_log[255], 255);
    push_run();
    wr_cnt   = 0;
    done_cnt = 0;
    t1       = cyc;
    @(negedge clk);
    start = 1'b0;
    check("restart_rd_en", rd_en, 1);
    check("restart_rd_addr", rd_addr, 0);
    wait_done(t1, "run2_done_cycle");
    check("writes_run2", wr_cnt, NWIN);
    @(negedge clk);

    // A single 0xFF in each read slot of window 5.
    foreach (offs[j]) begin
      for (int i = 0; i < MSIZE; i++) mem[i] = 8'h00;
      mem[10 + offs[j]] = 8'hFF;
      run_full("slot_run_done_cycle");
      check("slot_win5_ff", wr_log[5], 8'hFF);
      check("slot_win4_zero", wr_log[4], 8'h00);
    end

    // Uniform 0x80 map plus a window mixing values across the signed boundary.
    for (int i = 0; i < MSIZE; i++) mem[i] = 8'h80;
    mem[6]  = 8'h7F;
    mem[7]  = 8'h80;
    mem[22] = 8'h01;
    mem[23] = 8'h00;
    run_full("flat_run_done_cycle");
    check("unsigned_win3", wr_log[3], 8'h80);
    check("flat_win100", wr_log[100], 8'h80);

    // Abort a run with reset at cycle 100, then run again from window 0.
    for (int i = 0; i < MSIZE; i++) mem[i] = 8'(i);
    push_run();
    wr_cnt = 0;
    start  = 1'b1;
    t0     = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 100);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    check("writes_before_abort", wr_cnt, 19);
    rd_q.delete();
    wr_q.delete();
    rd_cnt = 0;
    reset  = 1'b0;
    repeat (20) @(negedge clk);
    run_full("post_reset_done_cycle");
    check("post_reset_k0", wr_log[0], 17);
    check("post_reset_k255", wr_log[255], 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
